rv32_multicycle_core: RTL and testbench

- Parametrised successor to the current 4-state SOC datapath: a multi-cycle RV32I core (full base integer ISA) with a generic memory bus and ready handshake.
- Sits between the Clockworks divider and the RAM/peripheral fabric; instruction and data traffic share one port.
- Adds what the current core lacks: loads/stores with byte/half/word lanes, branches, JAL/JALR, LUI/AUIPC, immediate ALU ops, a variable-latency memory wait, a configurable register count and reset vector, and a sticky halt on EBREAK/ECALL.

---
 rtl/rv32_multicycle_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_rv32_multicycle_core.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core with one shared memory port and a ready handshake.
// Each instruction is fetched, decoded and executed by an 8-state FSM; EBREAK/ECALL halt the core until reset.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          NUM_REGS   = 32
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [2:0]  state_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    localparam int          RIDX      = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - ADDR_WIDTH);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        WAIT_INSTR = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        LOAD       = 3'd4,
        WAIT_DATA  = 3'd5,
        STORE      = 3'd6,
        HALT       = 3'd7
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc, instr, rs1, rs2;
    logic [31:0] regs [NUM_REGS];

    // Instruction fields and immediates
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RIDX-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [31:0]     i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign rd_idx  = instr[7 +: RIDX];
    assign rs1_idx = instr[15 +: RIDX];
    assign rs2_idx = instr[20 +: RIDX];
    assign i_imm   = {{21{instr[31]}}, instr[30:20]};
    assign s_imm   = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    assign b_imm   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm   = {instr[31:12], 12'h000};
    assign j_imm   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    logic is_alu_reg, is_alu_imm, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_system, writes_rd;

    assign is_alu_reg = (opcode == 7'b0110011);
    assign is_alu_imm = (opcode == 7'b0010011);
    assign is_load    = (opcode == 7'b0000011);
    assign is_store   = (opcode == 7'b0100011);
    assign is_branch  = (opcode == 7'b1100011);
    assign is_jal     = (opcode == 7'b1101111);
    assign is_jalr    = (opcode == 7'b1100111);
    assign is_lui     = (opcode == 7'b0110111);
    assign is_auipc   = (opcode == 7'b0010111);
    assign is_system  = (opcode == 7'b1110011);
    assign writes_rd  = is_alu_reg | is_alu_imm | is_jal | is_jalr | is_lui | is_auipc;

    // ALU: register-register ops use rs2, immediate ops use the I-immediate
    logic [31:0] alu_in2, alu_out;
    logic [4:0]  shamt;

    assign alu_in2 = is_alu_reg ? rs2 : i_imm;
    assign shamt   = is_alu_reg ? rs2[4:0] : instr[24:20];

    always_comb begin
        unique case (funct3)
            3'd0:    alu_out = (is_alu_reg && instr[30]) ? rs1 - alu_in2 : rs1 + alu_in2;
            3'd1:    alu_out = rs1 << shamt;
            3'd2:    alu_out = {31'd0, $signed(rs1) < $signed(alu_in2)};
            3'd3:    alu_out = {31'd0, rs1 < alu_in2};
            3'd4:    alu_out = rs1 ^ alu_in2;
            3'd5:    alu_out = instr[30] ? 32'($signed(rs1) >>> shamt) : rs1 >> shamt;
            3'd6:    alu_out = rs1 | alu_in2;
            default: alu_out = rs1 & alu_in2;
        endcase
    end

    logic taken;
    always_comb begin
        unique case (funct3)
            3'd0:    taken = (rs1 == rs2);
            3'd1:    taken = (rs1 != rs2);
            3'd4:    taken = ($signed(rs1) < $signed(rs2));
            3'd5:    taken = ($signed(rs1) >= $signed(rs2));
            3'd6:    taken = (rs1 < rs2);
            3'd7:    taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] pc_plus4, pc_next, exec_result;
    assign pc_plus4 = pc + 32'd4;

    // Jump and branch targets always align down to a word; misalignment never traps
    always_comb begin
        if (is_jal)                  pc_next = (pc + j_imm) & ~32'h3;
        else if (is_jalr)            pc_next = (rs1 + i_imm) & ~32'h3;
        else if (is_branch && taken) pc_next = (pc + b_imm) & ~32'h3;
        else                         pc_next = pc_plus4;
    end

    always_comb begin
        if (is_lui)                 exec_result = u_imm;
        else if (is_auipc)          exec_result = pc + u_imm;
        else if (is_jal || is_jalr) exec_result = pc_plus4;
        else                        exec_result = alu_out;
    end

    // Load/store lanes
    logic [31:0] ls_addr, load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [3:0]  store_mask;

    assign ls_addr   = rs1 + (is_store ? s_imm : i_imm);
    assign load_half = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        unique case (ls_addr[1:0])
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        unique case (funct3[1:0])
            2'b00:   load_data = {{24{~funct3[2] & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{~funct3[2] & load_half[15]}}, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        unique case (funct3[1:0])
            2'b00: begin
                mem_wdata  = {4{rs2[7:0]}};
                store_mask = 4'b0001 << ls_addr[1:0];
            end
            2'b01: begin
                mem_wdata  = {2{rs2[15:0]}};
                store_mask = ls_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                mem_wdata  = rs2;
                store_mask = 4'b1111;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every flop samples the pre-edge values of the others.
        if (!resetn) state <= FETCH;
        else         state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        // NOTE: assigning a default first keeps every path driven and prevents an inferred latch.
        next_state = state;
        unique case (state)
            FETCH:      if (mem_rstrb) next_state = WAIT_INSTR;
            WAIT_INSTR: if (mem_ready) next_state = DECODE;
            DECODE:     next_state = EXECUTE;
            EXECUTE: begin
                if (is_load)        next_state = LOAD;
                else if (is_store)  next_state = STORE;
                else if (is_system) next_state = HALT;
                else                next_state = FETCH;
            end
            LOAD:       if (mem_rstrb) next_state = WAIT_DATA;
            WAIT_DATA:  if (mem_ready) next_state = FETCH;
            STORE:      if (mem_ready) next_state = FETCH;
            default:    next_state = HALT;
        endcase
    end

    // FSM outputs; strobes are registered one cycle ahead so they line up with FETCH/LOAD/STORE.
    // The cycle right after reset spends one FETCH cycle raising the first strobe.
    logic       rstrb_d;
    logic [3:0] wmask_d;
    always_comb begin
        rstrb_d  = (next_state == FETCH) || (next_state == LOAD);
        wmask_d  = (next_state == STORE && state != STORE) ? store_mask : 4'b0000;
        mem_addr = 32'd0;
        if (state == LOAD || state == WAIT_DATA || state == STORE)
            mem_addr = {ls_addr[31:2], 2'b00} & ADDR_MASK;
        else
            mem_addr = {pc[31:2], 2'b00} & ADDR_MASK;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc        <= RESET_ADDR;
            instr     <= NOP;
            halted    <= 1'b0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'b0000;
        end else begin
            mem_rstrb <= rstrb_d;
            mem_wmask <= wmask_d;
            unique case (state)
                WAIT_INSTR: if (mem_ready) instr <= mem_rdata;
                EXECUTE: begin
                    if (is_system)                            halted <= 1'b1;
                    else if (!is_load && !is_store)           pc     <= pc_next;
                end
                WAIT_DATA:  if (mem_ready) pc <= pc_plus4;
                STORE:      if (mem_ready) pc <= pc_plus4;
                default: ;
            endcase
        end
    end

    // Register file and operand latches
    logic        rf_we;
    logic [31:0] rf_wdata;
    assign rf_we    = resetn && (rd_idx != '0) &&
                      ((state == EXECUTE && writes_rd) || (state == WAIT_DATA && mem_ready));
    assign rf_wdata = (state == WAIT_DATA) ? load_data : exec_result;

    always_ff @(posedge clk) begin
        // NOTE: the register array has no reset so it maps onto RAM; x0 is forced to zero on read instead.
        if (rf_we) regs[rd_idx] <= rf_wdata;
        if (state == DECODE) begin
            rs1 <= (rs1_idx == '0) ? 32'd0 : regs[rs1_idx];
            rs2 <= (rs2_idx == '0) ? 32'd0 : regs[rs2_idx];
        end
    end

    assign state_out = state;
    assign pc_out    = pc;
    assign instr_out = instr;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench for rv32_multicycle_core: small programs run from a behavioural memory with
// configurable ready latency; results are stored by the programs and compared against constants.
module tb_rv32_multicycle_core;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        halted;
    logic [2:0]  state_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    rv32_multicycle_core dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .state_out (state_out),
        .pc_out    (pc_out),
        .instr_out (instr_out)
    );

    always #5 clk = ~clk;

    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // Behavioural memory: 1 KiB, ready arrives lat cycles after the request
    logic [31:0] mem [0:255];
    int          lat = 1;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'd0, load_data = 32'd0;
    logic        rd_ready = 1'b0, pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    assign mem_ready = rd_ready | ((lat == 1) && (mem_wmask != 4'b0000));

    always @(posedge clk) begin
        rd_ready <= 1'b0;
        if (load_en) mem[load_addr[9:2]] <= load_data;
        if (mem_wmask != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (lat > 1) begin
                pend <= 1'b1;
                cnt  <= lat - 1;
            end
        end else if (mem_rstrb) begin
            if (lat == 1) begin
                rd_ready  <= 1'b1;
                mem_rdata <= mem[mem_addr[9:2]];
            end else begin
                pend      <= 1'b1;
                cnt       <= lat - 1;
                pend_addr <= mem_addr;
            end
        end else if (pend) begin
            if (cnt == 1) begin
                rd_ready  <= 1'b1;
                mem_rdata <= mem[pend_addr[9:2]];
                pend      <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Bus protocol monitor
    logic       prev_rstrb = 1'b0;
    logic [3:0] prev_wmask = 4'b0000;
    int         rstrb_long = 0, wmask_long = 0, overlap = 0, halt_bus = 0;
    logic [3:0] sb_mask = 4'b0000, sh_mask = 4'b0000;

    always @(posedge clk) begin
        prev_rstrb <= mem_rstrb;
        prev_wmask <= mem_wmask;
        if (mem_rstrb && prev_rstrb)                       rstrb_long <= rstrb_long + 1;
        if (mem_wmask != 4'b0000 && prev_wmask != 4'b0000) wmask_long <= wmask_long + 1;
        if (mem_rstrb && mem_wmask != 4'b0000)             overlap    <= overlap + 1;
        if (halted && (mem_rstrb || mem_wmask != 4'b0000)) halt_bus   <= halt_bus + 1;
        if (mem_wmask != 4'b0000 && mem_addr == 32'h100)   sb_mask    <= mem_wmask;
        if (mem_wmask != 4'b0000 && mem_addr == 32'h244)   sh_mask    <= mem_wmask;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] addr);
        return mem[addr[9:2]];
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd_);
        return {f7, rs2, rs1, f3, rd_, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd_,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd_, op};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd_);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd_, 7'b1101111};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd_,
                                           input logic [6:0] op);
        return {imm, rd_, op};
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        load_addr = addr;
        load_data = data;
        load_en   = 1'b1;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
    endtask

    task automatic hold_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state_out == s) break;
            @(posedge clk);
            #1;
        end
        check(tag, {29'd0, state_out}, {29'd0, s});
    endtask

    task automatic wait_halt(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (halted) break;
            @(posedge clk);
            #1;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic load_prog1();
        poke(32'h00, i_type(12'd5,   5'd0, 3'd0, 5'd1, OP_IMM));
        poke(32'h04, i_type(12'hFFD, 5'd0, 3'd0, 5'd2, OP_IMM));
        poke(32'h08, r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        poke(32'h0C, r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
        poke(32'h10, i_type(12'd7,   5'd0, 3'd0, 5'd0, OP_IMM));
        poke(32'h14, s_type(12'h200, 5'd3, 5'd0, 3'd2));
        poke(32'h18, s_type(12'h204, 5'd4, 5'd0, 3'd2));
        poke(32'h1C, s_type(12'h208, 5'd0, 5'd0, 3'd2));
        poke(32'h20, s_type(12'h20C, 5'd2, 5'd0, 3'd2));
        poke(32'h24, EBREAK);
        for (int a = 32'h200; a <= 32'h20C; a += 4) poke(a, 32'hDEAD_BEEF);
    endtask

    task automatic check_prog1(input string p);
        check({p, "_add"},    rd(32'h200), 32'h0000_0002);
        check({p, "_sub"},    rd(32'h204), 32'h0000_0008);
        check({p, "_x0"},     rd(32'h208), 32'h0000_0000);
        check({p, "_addneg"}, rd(32'h20C), 32'hFFFF_FFFD);
        check({p, "_pc"},     pc_out,      32'h0000_0024);
    endtask

    task automatic load_prog3();
        poke(32'h00, i_type(12'h100, 5'd0,  3'd0, 5'd10, OP_IMM));
        poke(32'h04, i_type(12'd1,   5'd10, 3'd0, 5'd11, OP_LOAD));
        poke(32'h08, i_type(12'd1,   5'd10, 3'd4, 5'd12, OP_LOAD));
        poke(32'h0C, i_type(12'd2,   5'd10, 3'd1, 5'd13, OP_LOAD));
        poke(32'h10, i_type(12'd2,   5'd10, 3'd5, 5'd14, OP_LOAD));
        poke(32'h14, i_type(12'd0,   5'd10, 3'd2, 5'd15, OP_LOAD));
        poke(32'h18, i_type(12'h0AA, 5'd0,  3'd0, 5'd16, OP_IMM));
        poke(32'h1C, s_type(12'd3,   5'd16, 5'd10, 3'd0));
        poke(32'h20, s_type(12'h230, 5'd11, 5'd0, 3'd2));
        poke(32'h24, s_type(12'h234, 5'd12, 5'd0, 3'd2));
        poke(32'h28, s_type(12'h238, 5'd13, 5'd0, 3'd2));
        poke(32'h2C, s_type(12'h23C, 5'd14, 5'd0, 3'd2));
        poke(32'h30, s_type(12'h240, 5'd15, 5'd0, 3'd2));
        poke(32'h34, s_type(12'h246, 5'd16, 5'd0, 3'd1));
        poke(32'h38, EBREAK);
        poke(32'h100, 32'h8081_F2F3);
        poke(32'h244, 32'h1111_2222);
        for (int a = 32'h230; a <= 32'h240; a += 4) poke(a, 32'hDEAD_BEEF);
    endtask

    task automatic check_prog3(input string p);
        check({p, "_lb"},  rd(32'h230), 32'hFFFF_FFF2);
        check({p, "_lbu"}, rd(32'h234), 32'h0000_00F2);
        check({p, "_lh"},  rd(32'h238), 32'hFFFF_8081);
        check({p, "_lhu"}, rd(32'h23C), 32'h0000_8081);
        check({p, "_lw"},  rd(32'h240), 32'h8081_F2F3);
        check({p, "_sb"},  rd(32'h100), 32'hAA81_F2F3);
        check({p, "_sh"},  rd(32'h244), 32'h00AA_2222);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {29'd0, state_out}, 32'd0);
        check("rst_pc",    pc_out,             32'h0000_0000);
        check("rst_halt",  {31'd0, halted},    32'd0);
        check("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
        check("rst_instr", instr_out,          NOP);

        // Arithmetic, x0 protection
        load_prog1();
        resetn = 1'b1;
        wait_halt("p1_halt", 2000);
        check_prog1("p1");

        // Shifts, compares, LUI/AUIPC
        hold_reset();
        poke(32'h00, u_type(20'h80000, 5'd1, OP_LUI));
        poke(32'h04, i_type(12'h404, 5'd1, 3'd5, 5'd2, OP_IMM));
        poke(32'h08, i_type(12'h004, 5'd1, 3'd5, 5'd3, OP_IMM));
        poke(32'h0C, r_type(7'h00, 5'd0, 5'd1, 3'd2, 5'd4));
        poke(32'h10, r_type(7'h00, 5'd0, 5'd1, 3'd3, 5'd5));
        poke(32'h14, u_type(20'h00001, 5'd6, OP_AUIPC));
        poke(32'h18, i_type(12'hFFF, 5'd2, 3'd4, 5'd7, OP_IMM));
        poke(32'h1C, s_type(12'h210, 5'd2, 5'd0, 3'd2));
        poke(32'h20, s_type(12'h214, 5'd3, 5'd0, 3'd2));
        poke(32'h24, s_type(12'h218, 5'd4, 5'd0, 3'd2));
        poke(32'h28, s_type(12'h21C, 5'd5, 5'd0, 3'd2));
        poke(32'h2C, s_type(12'h220, 5'd6, 5'd0, 3'd2));
        poke(32'h30, s_type(12'h224, 5'd7, 5'd0, 3'd2));
        poke(32'h34, EBREAK);
        resetn = 1'b1;
        wait_halt("p2_halt", 2000);
        check("p2_srai",  rd(32'h210), 32'hF800_0000);
        check("p2_srli",  rd(32'h214), 32'h0800_0000);
        check("p2_slt",   rd(32'h218), 32'h0000_0001);
        check("p2_sltu",  rd(32'h21C), 32'h0000_0000);
        check("p2_auipc", rd(32'h220), 32'h0000_1014);
        check("p2_xori",  rd(32'h224), 32'h07FF_FFFF);

        // Byte/half lanes
        hold_reset();
        load_prog3();
        resetn = 1'b1;
        wait_halt("p3_halt", 3000);
        check_prog3("p3");
        check("p3_sb_mask", {28'd0, sb_mask}, 32'h8);
        check("p3_sh_mask", {28'd0, sh_mask}, 32'hC);

        // Branches and jumps
        hold_reset();
        poke(32'h00, i_type(12'd1,    5'd0, 3'd0, 5'd5, OP_IMM));
        poke(32'h04, i_type(12'd0,    5'd0, 3'd0, 5'd7, OP_IMM));
        poke(32'h08, b_type(13'd8,    5'd5, 5'd5, 3'd0));
        poke(32'h0C, i_type(12'h077,  5'd0, 3'd0, 5'd7, OP_IMM));
        poke(32'h10, b_type(13'd8,    5'd5, 5'd5, 3'd1));
        poke(32'h14, i_type(12'h055,  5'd0, 3'd0, 5'd8, OP_IMM));
        poke(32'h18, b_type(13'd8,    5'd5, 5'd0, 3'd4));
        poke(32'h1C, i_type(12'd1,    5'd7, 3'd0, 5'd7, OP_IMM));
        poke(32'h20, j_type(21'd16,   5'd1));
        poke(32'h24, s_type(12'h250,  5'd1, 5'd0, 3'd2));
        poke(32'h28, s_type(12'h254,  5'd7, 5'd0, 3'd2));
        poke(32'h2C, EBREAK);
        poke(32'h30, s_type(12'h258,  5'd8, 5'd0, 3'd2));
        poke(32'h34, i_type(12'd1,    5'd1, 3'd0, 5'd0, OP_JALR));
        for (int a = 32'h250; a <= 32'h258; a += 4) poke(a, 32'hDEAD_BEEF);
        resetn = 1'b1;
        wait_halt("p4_halt", 2000);
        check("p4_jal_link", rd(32'h250), 32'h0000_0024);
        check("p4_skipped",  rd(32'h254), 32'h0000_0000);
        check("p4_bne_fall", rd(32'h258), 32'h0000_0055);
        check("p4_pc",       pc_out,      32'h0000_002C);

        // EBREAK at 0x10 is terminal and silent
        hold_reset();
        for (int a = 0; a < 32'h10; a += 4) poke(a, NOP);
        poke(32'h10, EBREAK);
        resetn = 1'b1;
        wait_halt("p5_halt", 500);
        check("p5_state", {29'd0, state_out}, 32'd7);
        check("p5_pc",    pc_out,             32'h0000_0010);
        repeat (20) @(posedge clk);
        #1;
        check("p5_state_hold", {29'd0, state_out}, 32'd7);
        check("p5_pc_hold",    pc_out,             32'h0000_0010);
        check("p5_halt_hold",  {31'd0, halted},    32'd1);

        // Slow memory: same results, FSM waits in WAIT_INSTR
        lat = 3;
        hold_reset();
        load_prog1();
        resetn = 1'b1;
        wait_state("slow_wi_enter", 3'd1, 50);
        @(posedge clk); #1;
        check("slow_wi_hold1", {29'd0, state_out}, 32'd1);
        @(posedge clk); #1;
        check("slow_wi_hold2", {29'd0, state_out}, 32'd1);
        @(posedge clk); #1;
        check("slow_wi_done",  {29'd0, state_out}, 32'd2);
        wait_halt("slow1_halt", 4000);
        check_prog1("slow1");

        hold_reset();
        load_prog3();
        resetn = 1'b1;
        wait_halt("slow3_halt", 6000);
        check_prog3("slow3");

        // Reset while a load is outstanding; the late ready must not disturb the restart
        hold_reset();
        load_prog3();
        resetn = 1'b1;
        wait_state("mid_wd_enter", 3'd5, 200);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_state", {29'd0, state_out}, 32'd0);
        check("mid_rst_pc",    pc_out,             32'h0000_0000);
        check("mid_rst_halt",  {31'd0, halted},    32'd0);
        resetn = 1'b1;
        wait_halt("mid_halt", 6000);
        check_prog3("mid");

        check("bus_rstrb_one_cycle", rstrb_long, 32'd0);
        check("bus_wmask_one_cycle", wmask_long, 32'd0);
        check("bus_no_overlap",      overlap,    32'd0);
        check("bus_silent_halted",   halt_bus,   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
